sa_result_drain: RTL and testbench

SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

---
 rtl/sa_pkg.sv | 10 +
 rtl/sa_row_fifo.sv | 55 +++++
 rtl/sa_result_drain.sv | 126 ++++++++++++
 tb/tb_sa_result_drain.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared constants for the systolic-array result path: array geometry,
// accumulator width and drain FIFO depth, plus the row-index type.
package sa_pkg;
  localparam int SA_ROWS             = 8;
  localparam int SA_ACC_W            = 32;
  localparam int SA_DRAIN_FIFO_DEPTH = 4;
  localparam int SA_ROW_W            = $clog2(SA_ROWS);

  typedef logic [SA_ROW_W-1:0] sa_row_t;
endpackage

// File: rtl/sa_row_fifo.sv
// Per-row result FIFO with a combinational head (dout) so the drain stage can
// load and pop in the same edge. Full/empty come straight from an occupancy count.
module sa_row_fifo
  import sa_pkg::*;
#(
  parameter int DW    = SA_ACC_W,
  parameter int DEPTH = SA_DRAIN_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sa_result_drain.sv
// Collects per-row results into row FIFOs and serialises them round-robin onto
// a single valid/ready stream. Optional macro SA_DRAIN_RELU_EN clamps negative results to 0.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter int ROWS       = SA_ROWS,
  parameter int DW         = SA_ACC_W,
  parameter int FIFO_DEPTH = SA_DRAIN_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ROWS*DW-1:0]       rdata_in,
  input  logic [ROWS-1:0]          rvalid_in,
  output logic                     outread,
  output logic [DW-1:0]            m_data,
  output logic [$clog2(ROWS)-1:0]  m_row,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [15:0]              drain_count,
  output logic                     idle
);
  localparam int RW = $clog2(ROWS);

  logic [ROWS-1:0] full_vec;
  logic [ROWS-1:0] empty_vec;
  logic [ROWS-1:0] push_vec;
  logic [ROWS-1:0] pop_vec;
  logic [DW-1:0]   head [ROWS];

  logic            m_valid_q, m_valid_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic [RW-1:0]   m_row_q, m_row_d;
  logic [RW-1:0]   ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            load;
  logic            gnt_found;
  logic [RW-1:0]   gnt_row;
  logic [DW-1:0]   sel_data;
  logic [DW-1:0]   load_data;

  assign outread = ~|full_vec;
  assign load    = ~m_valid_q | m_ready;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign push_vec[gi] = outread & rvalid_in[gi];
      assign pop_vec[gi]  = load & gnt_found & (gnt_row == RW'(gi));
      sa_row_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_vec[gi]),
        .pop   (pop_vec[gi]),
        .din   (rdata_in[gi*DW +: DW]),
        .dout  (head[gi]),
        .full  (full_vec[gi]),
        .empty (empty_vec[gi])
      );
    end
  endgenerate

  // ptr_q holds the first row to search, i.e. one past the last granted row.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_row   = '0;
    idx       = 0;
    for (int k = 0; k < ROWS; k++) begin
      idx = (int'(ptr_q) + k) % ROWS;
      if (!gnt_found && !empty_vec[idx]) begin
        gnt_found = 1'b1;
        gnt_row   = RW'(idx);
      end
    end
  end

  assign sel_data = head[gnt_row];
`ifdef SA_DRAIN_RELU_EN
  assign load_data = sel_data[DW-1] ? '0 : sel_data;
`else
  assign load_data = sel_data;
`endif

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_row_d   = m_row_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (load) begin
      m_valid_d = gnt_found;
      if (gnt_found) begin
        m_data_d = load_data;
        m_row_d  = gnt_row;
        ptr_d    = (gnt_row == RW'(ROWS-1)) ? '0 : gnt_row + 1'b1;
      end
    end
    if (m_valid_q && m_ready) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_row_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_row_q   <= m_row_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_row       = m_row_q;
  assign drain_count = cnt_q;
  assign idle        = (&empty_vec) & ~m_valid_q;
endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain: queue-based reference model feeding an expected-beat
// scoreboard; a negedge monitor compares the DUT stream and status against it.
module tb_sa_result_drain;
  import sa_pkg::*;

  localparam int ROWS  = SA_ROWS;
  localparam int DW    = SA_ACC_W;
  localparam int DEPTH = SA_DRAIN_FIFO_DEPTH;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [ROWS*DW-1:0] rdata_in = '0;
  logic [ROWS-1:0]    rvalid_in = '0;
  logic               m_ready = 1'b0;
  logic               outread;
  logic [DW-1:0]      m_data;
  sa_row_t            m_row;
  logic               m_valid;
  logic [15:0]        drain_count;
  logic               idle;

  always #5 clk = ~clk;

  sa_result_drain #(
    .ROWS       (ROWS),
    .DW         (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rdata_in    (rdata_in),
    .rvalid_in   (rvalid_in),
    .outread     (outread),
    .m_data      (m_data),
    .m_row       (m_row),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .drain_count (drain_count),
    .idle        (idle)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 60)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: per-row queues of pending results plus one output slot.
  typedef struct packed {
    logic [7:0]    row;
    logic [DW-1:0] data;
  } beat_t;

  logic [DW-1:0] mq [ROWS][$];
  beat_t         expq [$];
  bit            mvld = 1'b0;
  int            mptr = 0;
  int            mcnt = 0;
  bit            started = 1'b0;
  bit            m_ord;
  bit            m_hit;

  function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] v);
`ifdef SA_DRAIN_RELU_EN
    return ($signed(v) < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic bit model_outread();
    for (int i = 0; i < ROWS; i++)
      if (mq[i].size() == DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_idle();
    for (int i = 0; i < ROWS; i++)
      if (mq[i].size() != 0) return 1'b0;
    return !mvld;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < ROWS; i++) mq[i].delete();
      expq.delete();
      mvld    = 1'b0;
      mptr    = 0;
      mcnt    = 0;
      started = 1'b1;
    end else begin
      m_ord = model_outread();
      if (mvld && m_ready) mcnt = (mcnt + 1) % 65536;
      if (!mvld || m_ready) begin
        m_hit = 1'b0;
        for (int k = 0; k < ROWS; k++) begin
          int r;
          r = (mptr + k) % ROWS;
          if (!m_hit && mq[r].size() > 0) begin
            beat_t b;
            m_hit  = 1'b1;
            b.row  = 8'(r);
            b.data = relu_ref(mq[r].pop_front());
            expq.push_back(b);
            mptr   = (r + 1) % ROWS;
          end
        end
        mvld = m_hit;
      end
      if (m_ord)
        for (int i = 0; i < ROWS; i++)
          if (rvalid_in[i]) mq[i].push_back(rdata_in[i*DW +: DW]);
    end
  end

  // Monitor: status every cycle, data/row on each handshake against the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", 64'(m_valid), 64'(mvld));
      chk("outread", 64'(outread), 64'(model_outread()));
      chk("idle", 64'(idle), 64'(model_idle()));
      chk("drain_count", 64'(drain_count), 64'(mcnt));
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected actual_row=%0d actual_data=%0h required=no_beat", m_row, m_data);
        end else begin
          beat_t b;
          b = expq.pop_front();
          chk("beat_row", 64'(m_row), 64'(b.row));
          chk("beat_data", 64'(m_data), 64'(b.data));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int r, input logic [DW-1:0] d);
    rdata_in[r*DW +: DW] = d;
  endtask

  initial begin
    int rr_prev;
    logic [DW-1:0] relu_exp;

    repeat (2) cyc();
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_row", 64'(m_row), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_outread", 64'(outread), 64'd1);
    rstn = 1'b1;

    // Single push on row 0
    m_ready = 1'b1;
    set_row(0, 32'd5);
    rvalid_in = 8'h01;
    cyc();
    rvalid_in = '0;
    cyc();
    chk("single_valid", 64'(m_valid), 64'd1);
    chk("single_data", 64'(m_data), 64'd5);
    chk("single_row", 64'(m_row), 64'd0);
    cyc();
    chk("single_count", 64'(drain_count), 64'd1);
    repeat (2) cyc();

    // All-row burst from a fresh round-robin pointer
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < ROWS; i++) set_row(i, DW'(i + 1));
    rvalid_in = 8'hFF;
    cyc();
    rvalid_in = '0;
    for (int i = 0; i < ROWS; i++) begin
      cyc();
      chk("burst_valid", 64'(m_valid), 64'd1);
      chk("burst_row", 64'(m_row), 64'(i));
      chk("burst_data", 64'(m_data), 64'(i + 1));
    end
    repeat (3) cyc();

    // Backpressure on row 3
    m_ready = 1'b0;
    rvalid_in = 8'h08;
    for (int k = 0; k < 8; k++) begin
      set_row(3, DW'(100 + k));
      cyc();
    end
    chk("bp_outread", 64'(outread), 64'd0);
    chk("bp_hold_data", 64'(m_data), 64'd100);
    chk("bp_hold_valid", 64'(m_valid), 64'd1);
    rvalid_in = '0;
    m_ready = 1'b1;
    repeat (7) cyc();

    // Round-robin between rows 2 and 5
    rr_prev = -1;
    rvalid_in = 8'h24;
    for (int k = 0; k < 8; k++) begin
      set_row(2, DW'(200 + k));
      set_row(5, DW'(300 + k));
      cyc();
      if (m_valid) begin
        if (rr_prev >= 0) chk("rr_alternate", 64'(m_row), (rr_prev == 2) ? 64'd5 : 64'd2);
        rr_prev = int'(m_row);
      end
    end
    rvalid_in = '0;
    repeat (14) cyc();

    // Reset while three results are buffered
    m_ready = 1'b0;
    rvalid_in = 8'h02;
    for (int k = 0; k < 3; k++) begin
      set_row(1, DW'(400 + k));
      cyc();
    end
    rvalid_in = '0;
    cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    chk("rstmid_valid", 64'(m_valid), 64'd0);
    chk("rstmid_idle", 64'(idle), 64'd1);
    chk("rstmid_count", 64'(drain_count), 64'd0);
    m_ready = 1'b1;
    repeat (4) cyc();
    chk("rstmid_no_stale", 64'(m_valid), 64'd0);

    // Negative result through the output register
`ifdef SA_DRAIN_RELU_EN
    relu_exp = '0;
`else
    relu_exp = 32'hFFFFFFF0;
`endif
    set_row(4, 32'hFFFFFFF0);
    rvalid_in = 8'h10;
    cyc();
    rvalid_in = '0;
    cyc();
    chk("relu_data", 64'(m_data), 64'(relu_exp));
    chk("relu_row", 64'(m_row), 64'd4);
    repeat (2) cyc();

    // Random traffic with random backpressure
    for (int n = 0; n < 3000; n++) begin
      rvalid_in = ROWS'($urandom);
      for (int i = 0; i < ROWS; i++) set_row(i, DW'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // Bounded drain
    rvalid_in = '0;
    m_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (idle && expq.size() == 0) break;
      cyc();
    end
    cyc();
    chk("final_idle", 64'(idle), 64'd1);
    chk("final_scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
